// File: rtl/fpmul_rr_arbiter_pkg.sv
// Shared types and constants for the FP multiplier round-robin arbiter.
package fp_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fpmul_rr_arbiter_if.sv
// Requester and multiplier signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the clients plus multiplier side.
interface fpmul_rr_arbiter_if
    import fp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = FP_W
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_op1;
    logic [N_REQ*W-1:0] req_op2;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_res;
    logic               rsp_err;
    logic               mul_ready;
    logic [W-1:0]       mul_op1;
    logic [W-1:0]       mul_op2;
    logic [W-1:0]       mul_res;
    logic               mul_done;

    modport slave (
        input  req_valid, req_op1, req_op2, mul_res, mul_done,
        output req_ready, rsp_valid, rsp_res, rsp_err, mul_ready, mul_op1, mul_op2
    );

    modport master (
        output req_valid, req_op1, req_op2, mul_res, mul_done,
        input  req_ready, rsp_valid, rsp_res, rsp_err, mul_ready, mul_op1, mul_op2
    );
endinterface

// File: rtl/fpmul_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);
    always_comb begin
        int idx;
        idx     = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any && req[PW'(idx)]) begin
                any              = 1'b1;
                gnt_oh[PW'(idx)] = 1'b1;
                gnt_idx          = PW'(idx);
            end
        end
    end
endmodule

// File: rtl/fpmul_rr_arbiter.sv
// Shares one FP multiplier among N_REQ requesters: round-robin grant, issue,
// wait for done or timeout, then a one-cycle result pulse to the winner.
module fpmul_rr_arbiter
    import fp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = FP_W,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    fpmul_rr_arbiter_if.slave    bus,
    output logic                 busy
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_res_q, rsp_res_d;
    logic             rsp_err_q, rsp_err_d;
    logic             mul_ready_q, mul_ready_d;
    logic [W-1:0]     mul_op1_q, mul_op1_d;
    logic [W-1:0]     mul_op2_q, mul_op2_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_res_d   = rsp_res_q;
        rsp_err_d   = rsp_err_q;
        mul_ready_d = 1'b0;
        mul_op1_d   = mul_op1_q;
        mul_op2_d   = mul_op2_q;
        case (state_q)
            IDLE: begin
                // Start pulse goes out together with the grant so the
                // multiplier sees it during the ISSUE cycle.
                if (pick_any) begin
                    gnt_d       = pick_idx;
                    mul_op1_d   = bus.req_op1[pick_idx*W +: W];
                    mul_op2_d   = bus.req_op2[pick_idx*W +: W];
                    req_ready_d = pick_oh;
                    mul_ready_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.mul_done) begin
                    rsp_res_d          = bus.mul_res;
                    rsp_err_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_res_d          = W'(FP_QNAN);
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end
            end
            RESP: begin
                ptr_d   = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
            mul_ready_q <= 1'b0;
            mul_op1_q   <= '0;
            mul_op2_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
            mul_ready_q <= mul_ready_d;
            mul_op1_q   <= mul_op1_d;
            mul_op2_q   <= mul_op2_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mul_ready = mul_ready_q;
    assign bus.mul_op1   = mul_op1_q;
    assign bus.mul_op2   = mul_op2_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Scoreboard bench for fpmul_rr_arbiter with a latency-programmable
// multiplier model and per-requester operand queues.
module tb_fpmul_rr_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int T = 8;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {logic [31:0] a; logic [31:0] b;} op_t;
    typedef struct packed {logic [31:0] res; logic err; logic [15:0] lat;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    fpmul_rr_arbiter_if #(.N_REQ(N), .W(W)) bus();
    fpmul_rr_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(T)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    op_t  req_q[N][$];
    exp_t exp_q[N][$];
    int   exp_gnt[$];
    bit   taken[N];
    int   checks = 0, errors = 0;
    int   cyc = 0, gnt_lane = -1, gnt_cyc = 0;
    int   rsp_cnt = 0, issue_cnt = 0;
    int   mdl_lat = 3;
    bit   mdl_never = 1'b0;
    int   stray_cnt = 0, stray_seen = 0, rem = 0;
    logic [31:0] m_a, m_b;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Known IEEE754 products; anything else gets an arbitrary but fixed mix.
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40200000}: return 32'h40A00000; // 2.0 * 2.5
            {32'h3FA00000, 32'h3F800000}: return 32'h3FA00000; // 1.25 * 1.0
            {32'h40400000, 32'h40400000}: return 32'h41100000; // 3 * 3
            {32'h3F000000, 32'h40800000}: return 32'h40000000; // 0.5 * 4
            {32'hC0000000, 32'h40000000}: return 32'hC0800000; // -2 * 2
            default: return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    function automatic int lane_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic send(int i, logic [31:0] a, logic [31:0] b);
        op_t  o;
        exp_t e;
        o.a = a;
        o.b = b;
        req_q[i].push_back(o);
        e.err = mdl_never || (mdl_lat > T);
        e.res = e.err ? QNAN : fmul(a, b);
        e.lat = e.err ? 16'(T + 1) : 16'(mdl_lat + 1);
        exp_q[i].push_back(e);
    endtask

    task automatic wait_idle(string tag, int budget);
        bit ok;
        int pend;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            pend = exp_gnt.size();
            for (int i = 0; i < N; i++) pend += exp_q[i].size() + req_q[i].size();
            ok = (pend == 0) && !busy;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold operands through the grant edge, then move to the next.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (taken[i]) begin
                if (req_q[i].size() > 0) req_q[i].delete(0);
                taken[i] = 1'b0;
            end
            if (bus.req_ready[i]) taken[i] = 1'b1;
            if (!taken[i]) begin
                bus.req_valid[i] = (req_q[i].size() > 0);
                if (req_q[i].size() > 0) begin
                    bus.req_op1[i*W +: W] = req_q[i][0].a;
                    bus.req_op2[i*W +: W] = req_q[i][0].b;
                end
            end
        end
    end

    // Multiplier model: done L cycles after the start pulse, plus injectable strays.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mul_done <= 1'b0;
            bus.mul_res  <= '0;
            rem          <= 0;
            stray_seen   <= stray_cnt;
        end else begin
            bus.mul_done <= 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen   <= stray_cnt;
                bus.mul_done <= 1'b1;
                bus.mul_res  <= 32'hDEADBEEF;
            end
            if (bus.mul_ready && !mdl_never) begin
                m_a <= bus.mul_op1;
                m_b <= bus.mul_op2;
                if (mdl_lat == 1) begin
                    bus.mul_done <= 1'b1;
                    bus.mul_res  <= fmul(bus.mul_op1, bus.mul_op2);
                end else begin
                    rem <= mdl_lat - 1;
                end
            end else if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    bus.mul_done <= 1'b1;
                    bus.mul_res  <= fmul(m_a, m_b);
                end
            end
        end
    end

    // Monitor: grant order, issue operands, response value/error/latency.
    always @(negedge clk) begin
        int   l;
        exp_t e;
        if (rst) begin
            if (bus.mul_ready) issue_cnt++;
            if (bus.req_ready != '0) begin
                l = lane_of(bus.req_ready);
                chk("gnt_onehot", 64'($onehot(bus.req_ready)), 64'd1);
                chk("issue_with_gnt", 64'(bus.mul_ready), 64'd1);
                chk("busy_at_gnt", 64'(busy), 64'd1);
                if (exp_gnt.size() > 0) chk("gnt_order", 64'(l), 64'(exp_gnt.pop_front()));
                else chk("gnt_unexpected", 64'(bus.req_ready), 64'd0);
                if (req_q[l].size() > 0) begin
                    chk("issue_op1", 64'(bus.mul_op1), 64'(req_q[l][0].a));
                    chk("issue_op2", 64'(bus.mul_op2), 64'(req_q[l][0].b));
                end
                gnt_lane = l;
                gnt_cyc  = cyc;
            end else if (bus.mul_ready) begin
                chk("issue_without_gnt", 64'(bus.mul_ready), 64'd0);
            end
            if (bus.rsp_valid != '0) begin
                rsp_cnt++;
                l = lane_of(bus.rsp_valid);
                chk("rsp_onehot", 64'($onehot(bus.rsp_valid)), 64'd1);
                chk("rsp_lane", 64'(l), 64'(gnt_lane));
                if (exp_q[l].size() > 0) begin
                    e = exp_q[l].pop_front();
                    chk("rsp_res", 64'(bus.rsp_res), 64'(e.res));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                    chk("rsp_latency", 64'(cyc - gnt_cyc), 64'(e.lat));
                end else begin
                    chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end
            end
        end
    end

    initial begin
        int r0, i0;
        bit seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_res",   64'(bus.rsp_res),   64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst_mul_ready", 64'(bus.mul_ready), 64'd0);
        chk("rst_mul_op1",   64'(bus.mul_op1),   64'd0);
        chk("rst_mul_op2",   64'(bus.mul_op2),   64'd0);
        chk("rst_busy",      64'(busy),          64'd0);
        @(negedge clk) rst = 1'b1;

        // Single request, L=3: grant in cycle 1, response in cycle 5
        @(posedge clk); #1;
        mdl_lat = 3;
        i0 = issue_cnt;
        exp_gnt.push_back(0);
        send(0, 32'h40000000, 32'h40200000);
        @(negedge clk);
        chk("p1_no_early_gnt", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("p1_gnt_cycle1", 64'(bus.req_ready), 64'd1);
        wait_idle("p1_drain", 50);
        chk("p1_single_issue", 64'(issue_cnt - i0), 64'd1);

        // Round robin with all requesters valid from reset release
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_lat = 2;
        send(0, 32'h40400000, 32'h40400000);
        send(1, 32'h3FA00000, 32'h3F800000);
        send(2, 32'h3F000000, 32'h40800000);
        send(3, 32'hC0000000, 32'h40000000);
        send(0, 32'h12345678, 32'h9ABCDEF0);
        exp_gnt = '{0, 1, 2, 3, 0};
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        wait_idle("p2_drain", 200);

        // L=1, then rotation from ptr=2: requester 3 ahead of 0
        @(posedge clk); #1;
        mdl_lat = 1;
        exp_gnt.push_back(1);
        send(1, 32'h3FA00000, 32'h3F800000);
        wait_idle("p3a_drain", 50);
        @(posedge clk); #1;
        exp_gnt = '{3, 0};
        send(0, 32'h40000000, 32'h40200000);
        send(3, 32'h40400000, 32'h40400000);
        wait_idle("p3b_drain", 100);

        // Timeout, then a stray done in IDLE must be ignored
        @(posedge clk); #1;
        mdl_never = 1'b1;
        exp_gnt.push_back(1);
        send(1, 32'h40400000, 32'h40400000);
        wait_idle("p4_drain", 100);
        mdl_never = 1'b0;
        r0 = rsp_cnt;
        stray_cnt++;
        repeat (6) @(negedge clk);
        chk("stray_no_rsp", 64'(rsp_cnt), 64'(r0));
        chk("stray_idle", 64'(busy), 64'd0);
        chk("stray_res_hold", 64'(bus.rsp_res), 64'(QNAN));

        // Reset during WAIT aborts the in-flight request
        @(posedge clk); #1;
        mdl_lat = 6;
        exp_gnt.push_back(2);
        send(2, 32'h3F000000, 32'h40800000);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.mul_ready;
        end
        chk("p5_issue_seen", 64'(seen), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_q[2].delete();
        chk("p5_rst_busy",      64'(busy),          64'd0);
        chk("p5_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("p5_rst_mul_ready", 64'(bus.mul_ready), 64'd0);
        chk("p5_rst_mul_op1",   64'(bus.mul_op1),   64'd0);
        chk("p5_rst_mul_op2",   64'(bus.mul_op2),   64'd0);
        chk("p5_rst_rsp_res",   64'(bus.rsp_res),   64'd0);
        r0 = rsp_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        chk("p5_no_rsp", 64'(rsp_cnt), 64'(r0));
        @(posedge clk); #1;
        mdl_lat = 4;
        exp_gnt = '{0, 3};
        send(3, 32'hC0000000, 32'h40000000);
        send(0, 32'h3FA00000, 32'h3F800000);
        wait_idle("p5_drain", 100);

        // done on the same cycle the counter reaches TIMEOUT-1
        @(posedge clk); #1;
        mdl_lat = T;
        exp_gnt.push_back(3);
        send(3, 32'hC0000000, 32'h40000000);
        wait_idle("p6_drain", 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpmul_rr_arbiter.md
# fpmul_rr_arbiter

Round-robin arbiter and sequencer that shares one single-precision IEEE754 multiplier (`double_multipler`-style handshake: `ready` start, `op1`/`op2` in, `res`/`done` out) between `N_REQ` requesters. It accepts one operand pair at a time, issues it to the multiplier, and waits for `done` or a timeout. It then returns the product to the granted requester with a one-cycle pulse. The block sits between the FP multiplier and the client units that need multiplications.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 32, operand/result width (single precision)
- `TIMEOUT`, 64, max cycles waited for `mul_done` before aborting

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  N_REQ  request per requester; held with operands until its `req_ready` pulse
- `req_op1`  in  N_REQ*W  operand 1, requester i at bits [i*W +: W]
- `req_op2`  in  N_REQ*W  operand 2, same packing
- `req_ready`  out  N_REQ  one-hot, one-cycle grant/accept pulse
- `rsp_valid`  out  N_REQ  one-hot, one-cycle result pulse
- `rsp_res`  out  W  result, valid while any `rsp_valid` bit is high
- `rsp_err`  out  1  high with `rsp_valid` when the result is a timeout abort
- `mul_ready`  out  1  one-cycle start pulse to the multiplier
- `mul_op1`, `mul_op2`  out  W  operands to the multiplier, stable from issue until `mul_done` or abort
- `mul_res`  in  W  multiplier result
- `mul_done`  in  1  multiplier completion pulse
- `busy`  out  1  high in every state except IDLE

## Operation
- Every output is registered.
- Reset (`rst`=0) state:
  - FSM in IDLE, rotation pointer `ptr`=0, timeout counter 0.
  - All outputs are 0, including `rsp_res`, `mul_op1` and `mul_op2`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, pick the first set index at or after `ptr`, wrapping modulo N_REQ, and store it as `gnt`.
  - Latch that requester's operands into `mul_op1`/`mul_op2`.
  - Pulse `req_ready[gnt]` and go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:** `mul_ready`=1 for exactly this cycle; clear the counter; go to WAIT.
- **WAIT:** the counter increments each cycle.
  - `mul_done`=1: capture `mul_res` into `rsp_res` with `rsp_err`=0, go to RESP.
  - Else, counter reaches TIMEOUT-1: set `rsp_res`=32'h7FC00000 (quiet NaN) with `rsp_err`=1, go to RESP.
  - `mul_done` and timeout in the same cycle: `mul_done` wins.
- **RESP:**
  - Pulse `rsp_valid[gnt]` for one cycle.
  - Set `ptr` = (gnt+1) mod N_REQ and go to IDLE.
  - `rsp_res` and `rsp_err` then hold until the next capture; they are only meaningful while `rsp_valid` is high.
- `mul_done` outside WAIT is ignored, as a stray or late completion.
- A requester that drops `req_valid` before its grant is simply not selected; no error is raised.
- `req_valid` seen in non-IDLE states is not sampled.
- `ptr` advances only after a served request, so each requester waits at most N_REQ-1 other transactions.
- Asserting reset mid-operation aborts at once:
  - No `rsp_valid` is produced for the in-flight request.
  - `mul_ready` drops immediately.

## Timing
- The edge ending IDLE cycle 0 samples `req_valid`.
  - `req_ready[gnt]` and `mul_ready` are both high in cycle 1, while in ISSUE.
- Multiplier `done` pulse in cycle 1+L:
  - The arbiter samples it in WAIT.
  - `rsp_valid` is high in cycle 2+L.
  - IDLE in cycle 3+L.
- The earliest next grant is pulsed in cycle 4+L.
- Grant-to-response latency = L+1 cycles; issue-to-issue period = L+3 cycles.
- Timeout case: `rsp_valid` is asserted TIMEOUT+1 cycles after `mul_ready`.
- A requester must hold its operands until the edge on which it sees its `req_ready`=1, then may change them or drop the request.

## Structure
- Shared package `fp_pkg`:
  - FSM state typedef (`arb_state_t`: IDLE, ISSUE, WAIT, RESP).
  - `FP_QNAN` = 32'h7FC00000.
  - `FP_W` = 32.
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant and index, plus an `any` flag.
  - Verified standalone.
- The top module holds the FSM, counter, operand/result registers and `ptr`.

## Test plan
- Single request:
  - Stimulus: bench multiplier model L=3; requester 0 sends 2.0 (32'h40000000) × 2.5 (32'h40200000).
  - Expected: `req_ready[0]` in cycle 1, `mul_ready` once, `rsp_valid[0]` in cycle 5 with `rsp_res`=32'h40A00000 (5.0), `rsp_err`=0.
- Round robin:
  - Stimulus: all 4 requesters valid from reset release.
  - Expected: grants in order 0,1,2,3,0; requester 1 sends 1.25 × 1.0 and gets 32'h3FA00000.
- Rotation from `ptr`=2:
  - Stimulus: only requesters 0 and 3 valid.
  - Expected: 3 is granted before 0.
- Timeout:
  - Stimulus: model never asserts `done`, TIMEOUT=8.
  - Expected: `rsp_valid` 9 cycles after `mul_ready` with `rsp_res`=32'h7FC00000 and `rsp_err`=1.
  - Then: a late `mul_done` in IDLE produces no response.
- Reset mid-operation:
  - Stimulus: `rst`=0 asserted during WAIT.
  - Expected: all outputs 0 at once, no `rsp_valid`; after release, `ptr`=0 and a new request completes normally.
- Simultaneous `mul_done` and timeout in the same cycle:
  - Expected: the result is taken from `mul_res` with `rsp_err`=0.
